// File: rtl/fmesh_lookahead_route_encoder.sv
// fmesh_lookahead_route_encoder
// Look-ahead route encoder for a folded-mesh router. On each accepted head
// flit the destination endpoint address {ep,ey,ex} is compared against this
// router's coordinates, producing a {x,y,a,b} direction code and, for local
// delivery, the destination port number. Body/tail flits reuse the route
// latched at the head. A single output register stage with valid/ready
// handshake presents one result per accepted flit, in order.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   current_x/current_y this router's coordinates (sampled on head accept)
//   in_valid/in_ready   input flit handshake
//   in_hdr/in_tail      head / tail flit flags
//   dest_e_addr         destination endpoint {ep,ey,ex} (head flits only)
//   out_valid/out_ready output result handshake
//   dest_port_coded     {x,y,a,b} route code
//   endp_localp_num     destination local port when a=b=0
//   addr_err            result belongs to a packet with an invalid address
//   proto_err           sticky protocol-error flag (missing tail / orphan flit)
module fmesh_lookahead_route_encoder #(
  parameter int NX    = 4,
  parameter int NY    = 4,
  parameter int NL    = 1,
  parameter int EAw   = 7,
  parameter int PLw   = 3,
  parameter int DSTPw = 4,
  localparam int EXw  = $clog2(NX),
  localparam int EYw  = $clog2(NY),
  localparam int EPw  = EAw - EXw - EYw,
  localparam int P    = 4 + NL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [EXw-1:0]   current_x,
  input  logic [EYw-1:0]   current_y,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_hdr,
  input  logic             in_tail,
  input  logic [EAw-1:0]   dest_e_addr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSTPw-1:0] dest_port_coded,
  output logic [PLw-1:0]   endp_localp_num,
  output logic             addr_err,
  output logic             proto_err
);

  typedef enum logic {IDLE, IN_PKT} state_t;

  typedef struct packed {
    logic [DSTPw-1:0] code;
    logic [PLw-1:0]   lp;
    logic             err;
  } route_t;

  state_t state_q, state_d;
  route_t route_q, route_d;
  route_t out_q, out_d;
  route_t head_route;
  logic   out_valid_q, out_valid_d;
  logic   proto_err_q, proto_err_d;
  logic   accept;

  logic [EXw-1:0] dx;
  logic [EYw-1:0] dy;
  logic [EPw-1:0] dp;
  logic           a_bit, b_bit, x_bit, y_bit, addr_ok;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  assign dx = dest_e_addr[EXw-1:0];
  assign dy = dest_e_addr[EXw+EYw-1:EXw];
  assign dp = dest_e_addr[EAw-1:EXw+EYw];

  // Route computation for the incoming head flit
  always_comb begin
    addr_ok = (32'(dx) <= 32'(NX - 1)) &&
              (32'(dy) <= 32'(NY - 1)) &&
              (32'(dp) <= 32'(P - 1));
    a_bit   = (dx != current_x);
    b_bit   = (dy != current_y);
    x_bit   = a_bit && (dx > current_x);
    y_bit   = b_bit && (dy < current_y);
    head_route      = '0;
    head_route.err  = !addr_ok;
    if (addr_ok) begin
      head_route.code = DSTPw'({x_bit, y_bit, a_bit, b_bit});
      head_route.lp   = (!a_bit && !b_bit) ? PLw'(dp) : '0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (in_hdr) begin
        state_d = in_tail ? IDLE : IN_PKT;
      end else if (state_q == IN_PKT && in_tail) begin
        state_d = IDLE;
      end
    end
  end

  // Output / datapath logic
  always_comb begin
    route_d     = route_q;
    out_d       = out_q;
    out_valid_d = out_valid_q && !out_ready;
    proto_err_d = proto_err_q;
    if (accept) begin
      out_valid_d = 1'b1;
      if (in_hdr) begin
        // A head while already in a packet means the previous tail was lost;
        // flag it and restart with the new head's route.
        if (state_q == IN_PKT) begin
          proto_err_d = 1'b1;
        end
        route_d = head_route;
        out_d   = head_route;
      end else if (state_q == IN_PKT) begin
        out_d = route_q;
      end else begin
        proto_err_d = 1'b1;
        out_d       = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      route_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      route_q     <= route_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign dest_port_coded = out_q.code;
  assign endp_localp_num = out_q.lp;
  assign addr_err        = out_q.err;
  assign proto_err       = proto_err_q;

endmodule

// File: tb/tb_fmesh_lookahead_route_encoder.sv
module tb_fmesh_lookahead_route_encoder;

  localparam int NX = 4, NY = 4, NL = 1, EAw = 7, PLw = 3, DSTPw = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       current_x, current_y;
  logic             in_valid, in_ready, in_hdr, in_tail;
  logic [EAw-1:0]   dest_e_addr;
  logic             out_valid, out_ready;
  logic [DSTPw-1:0] dest_port_coded;
  logic [PLw-1:0]   endp_localp_num;
  logic             addr_err, proto_err;

  fmesh_lookahead_route_encoder #(
    .NX(NX), .NY(NY), .NL(NL), .EAw(EAw), .PLw(PLw), .DSTPw(DSTPw)
  ) dut (
    .clk(clk), .reset(reset),
    .current_x(current_x), .current_y(current_y),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_hdr(in_hdr), .in_tail(in_tail), .dest_e_addr(dest_e_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .dest_port_coded(dest_port_coded), .endp_localp_num(endp_localp_num),
    .addr_err(addr_err), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int code;
    int lp;
    int err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model state
  bit   m_in_pkt = 0;
  bit   m_proto  = 0;
  exp_t m_route  = '{0, 0, 0};
  bit   acc_pending = 0;
  exp_t pend = '{0, 0, 0};

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_route(input int dx, input int dy, input int dp,
                                     input int cx, input int cy);
    exp_t r;
    if (dx >= NX || dy >= NY || dp >= 4 + NL) begin
      r = '{0, 0, 1};
    end else begin
      r.code = ((dx > cx) ? 8 : 0) + ((dy < cy) ? 4 : 0) +
               ((dx != cx) ? 2 : 0) + ((dy != cy) ? 1 : 0);
      r.lp   = (dx == cx && dy == cy) ? (dp % (1 << PLw)) : 0;
      r.err  = 0;
    end
    return r;
  endfunction

  task automatic model_accept(input bit h, input bit t, input int ep, input int ey,
                              input int ex, input int cx, input int cy);
    if (h) begin
      if (m_in_pkt) m_proto = 1;
      m_route  = ref_route(ex, ey, ep, cx, cy);
      pend     = m_route;
      m_in_pkt = !t;
    end else if (m_in_pkt) begin
      pend = m_route;
      if (t) m_in_pkt = 0;
    end else begin
      m_proto = 1;
      pend    = '{0, 0, 0};
    end
  endtask

  // One clock of stimulus; results accepted this cycle become visible after
  // the next rising edge, so they join the scoreboard at that edge.
  task automatic cycle(input bit v, input bit h, input bit t, input int ep,
                       input int ey, input int ex, input bit ordy,
                       input int cx, input int cy);
    @(posedge clk);
    if (acc_pending) begin
      sb.push_back(pend);
      acc_pending = 0;
    end
    #2;
    in_valid    = v;
    in_hdr      = h;
    in_tail     = t;
    dest_e_addr = 7'(ep * 16 + ey * 4 + ex);
    out_ready   = ordy;
    current_x   = 2'(cx);
    current_y   = 2'(cy);
    #1;
    chk("proto_err", proto_err, m_proto);
    if (v && in_ready) begin
      model_accept(h, t, ep, ey, ex, cx, cy);
      acc_pending = 1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset    = 0;
    in_valid = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_code", dest_port_coded, 0);
    chk("rst_lp", endp_localp_num, 0);
    chk("rst_addr_err", addr_err, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_in_ready", in_ready, 1);
    sb.delete();
    acc_pending = 0;
    m_in_pkt    = 0;
    m_proto     = 0;
    m_route     = '{0, 0, 0};
    @(posedge clk);
    #2;
    reset = 1;
  endtask

  // Monitor: scoreboard pop/compare on each output handshake
  always @(negedge clk) begin
    chk("out_valid", out_valid, (sb.size() != 0) ? 1 : 0);
    chk("in_ready", in_ready, (!out_valid || out_ready) ? 1 : 0);
    if (out_valid && sb.size() != 0) begin
      chk("code", dest_port_coded, sb[0].code);
      chk("localp", endp_localp_num, sb[0].lp);
      chk("addr_err", addr_err, sb[0].err);
      if (out_ready) void'(sb.pop_front());
    end
  end

  int dir [10][5] = '{
    '{1, 1, 0, 0, 3},   // single flit east/north -> 1111
    '{1, 0, 0, 2, 0},   // head west/south -> 0011
    '{0, 0, 0, 0, 0},   // body
    '{0, 0, 5, 3, 3},   // body, dest bits ignored
    '{0, 1, 7, 3, 2},   // tail
    '{1, 1, 2, 1, 1},   // local, port 2
    '{1, 1, 6, 1, 1},   // invalid ep
    '{0, 1, 0, 0, 0},   // orphan tail in IDLE
    '{1, 0, 0, 0, 2},   // head
    '{1, 1, 1, 3, 1}    // head without prior tail
  };

  initial begin
    reset       = 0;
    in_valid    = 0;
    in_hdr      = 0;
    in_tail     = 0;
    dest_e_addr = '0;
    out_ready   = 1;
    current_x   = 2'd1;
    current_y   = 2'd1;
    #1;
    chk("init_out_valid", out_valid, 0);
    chk("init_code", dest_port_coded, 0);
    chk("init_lp", endp_localp_num, 0);
    chk("init_addr_err", addr_err, 0);
    chk("init_proto_err", proto_err, 0);
    chk("init_in_ready", in_ready, 1);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1;

    foreach (dir[i])
      cycle(1, dir[i][0] != 0, dir[i][1] != 0, dir[i][2], dir[i][3], dir[i][4], 1, 1, 1);

    // Stall for several cycles with a result pending, then release
    cycle(1, 1, 1, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) cycle(1, 1, 1, 0, 2, 2, 0, 1, 1);
    for (int i = 0; i < 2; i++) cycle(1, 1, 1, 0, 2, 2, 1, 1, 1);

    // Reset in the middle of a packet
    cycle(1, 1, 0, 0, 3, 2, 1, 1, 1);
    cycle(1, 0, 0, 0, 0, 0, 1, 1, 1);
    do_reset();
    cycle(1, 1, 1, 0, 1, 0, 1, 1, 1);
    cycle(1, 0, 0, 0, 0, 0, 1, 1, 1);

    // Randomized traffic with moving coordinates and back-pressure
    for (int i = 0; i < 3000; i++) begin
      if (i % 750 == 749) do_reset();
      cycle($urandom_range(9, 0) < 7, $urandom_range(9, 0) < 4,
            $urandom_range(1, 0) == 1, int'($urandom_range(7, 0)),
            int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
            $urandom_range(9, 0) < 7, int'($urandom_range(3, 0)),
            int'($urandom_range(3, 0)));
    end

    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0, 1, 1, 1);
    @(posedge clk);
    #3;
    chk("drain_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
